// File: rtl/sa_3_bit_en_sequencer.sv
// Run sequencer for the 3-lane systolic-array enable path.
// One accepted start steps cnt through 0..LAST_CNT; each unstalled RUN cycle
// drives the lane-enable pattern for the current step.
module sa_3_bit_en_sequencer #(
   parameter int unsigned LAST_CNT = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       stall,
   input  logic       abort,
   output logic [3:0] cnt,
   output logic [2:0] en,
   output logic       busy,
   output logic       start_ack,
   output logic       done
);

   localparam logic [3:0] LastCnt = 4'(LAST_CNT);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   // State and step-count registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, next-count and start handshake.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      start_ack = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = 4'd0;
            if (start) begin
               start_ack = 1'b1;
               state_d   = StRun;
            end
         end
         StRun: begin
            // Abort outranks both stall and the final-step transition.
            if (abort) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else if (!stall) begin
               if (cnt_q >= LastCnt) begin
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         StDone: begin
            // Restart straight from DONE gives back-to-back runs.
            cnt_d = 4'd0;
            if (start) begin
               start_ack = 1'b1;
               state_d   = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Lane-enable decode; bubbles whenever not running or stalled.
   always_comb begin
      en = 3'b000;
      if ((state_q == StRun) && !stall) begin
         case (cnt_q)
            4'd0:    en = 3'b111;
            4'd1:    en = 3'b101;
            4'd2:    en = 3'b010;
            4'd3:    en = 3'b100;
            4'd4:    en = 3'b010;
            4'd5:    en = 3'b001;
            4'd6:    en = 3'b110;
            4'd7:    en = 3'b001;
            4'd8:    en = 3'b111;
            default: en = 3'b000;
         endcase
      end
   end

   assign cnt  = cnt_q;
   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);

endmodule

// File: tb/tb_sa_3_bit_en_sequencer.sv
// Self-checking bench for sa_3_bit_en_sequencer: per-cycle scoreboard against
// a behavioural model, plus run-level latency and count checks.
module tb_sa_3_bit_en_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       start = 1'b0;
   logic       stall = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] cnt;
   logic [2:0] en;
   logic       busy;
   logic       start_ack;
   logic       done;

   sa_3_bit_en_sequencer #(.LAST_CNT(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .stall     (stall),
      .abort     (abort),
      .cnt       (cnt),
      .en        (en),
      .busy      (busy),
      .start_ack (start_ack),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] cnt;
      logic [2:0] en;
      logic       busy;
      logic       ack;
      logic       done;
   } exp_t;

   exp_t exp_q[$];

   logic [2:0] pat [0:8];
   int m_state;  // 0 idle, 1 run, 2 done
   int m_cnt;

   int n_total = 0;
   int n_bad   = 0;

   int cyc;
   int done_at;
   int busy_cnt;
   int en_cnt;
   int ack_cnt;
   int s;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.cnt  = 4'(m_cnt);
      e.busy = (m_state == 1);
      e.done = (m_state == 2);
      e.ack  = start && (m_state != 1);
      e.en   = (m_state == 1 && !stall) ? pat[m_cnt] : 3'b000;
      return e;
   endfunction

   task automatic model_update();
      case (m_state)
         0: if (start) begin m_state = 1; m_cnt = 0; end
         1: begin
            if (abort) begin
               m_state = 0; m_cnt = 0;
            end else if (!stall) begin
               if (m_cnt == 8) m_state = 2;
               else m_cnt++;
            end
         end
         default: begin
            if (start) begin m_state = 1; m_cnt = 0; end
            else begin m_state = 0; m_cnt = 0; end
         end
      endcase
   endtask

   // One clock: expectations pushed from the model, popped and compared at negedge.
   task automatic cycle();
      exp_t e;
      cyc++;
      @(negedge clk);
      exp_q.push_back(model_out());
      e = exp_q.pop_front();
      check_eq("cnt", 32'(cnt), 32'(e.cnt));
      check_eq("en", 32'(en), 32'(e.en));
      check_eq("busy", 32'(busy), 32'(e.busy));
      check_eq("start_ack", 32'(start_ack), 32'(e.ack));
      check_eq("done", 32'(done), 32'(e.done));
      if (done === 1'b1 && done_at < 0) done_at = cyc;
      if (busy === 1'b1) busy_cnt++;
      if (en !== 3'b000) en_cnt++;
      if (start_ack === 1'b1) ack_cnt++;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clear_stats();
      done_at  = -1;
      busy_cnt = 0;
      en_cnt   = 0;
      ack_cnt  = 0;
   endtask

   // Pulse start for one cycle; s is the cycle whose closing edge accepts it.
   task automatic start_pulse();
      clear_stats();
      start = 1'b1;
      cycle();
      s = cyc;
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      pat[0] = 3'b111; pat[1] = 3'b101; pat[2] = 3'b010; pat[3] = 3'b100;
      pat[4] = 3'b010; pat[5] = 3'b001; pat[6] = 3'b110; pat[7] = 3'b001;
      pat[8] = 3'b111;
      m_state = 0;
      m_cnt   = 0;
      cyc     = 0;
      clear_stats();

      // Reset state
      #1 reset_n = 1'b0;
      #1;
      check_eq("rst_cnt", 32'(cnt), 32'd0);
      check_eq("rst_en", 32'(en), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) cycle();

      // Plain run
      start_pulse();
      repeat (12) cycle();
      check_eq("run1_done_lat", 32'(done_at - s), 32'd10);
      check_eq("run1_busy_cycles", 32'(busy_cnt), 32'd9);
      check_eq("run1_en_cycles", 32'(en_cnt), 32'd9);

      // Stall 3 cycles at cnt=4
      start_pulse();
      repeat (4) cycle();
      stall = 1'b1;
      repeat (3) cycle();
      stall = 1'b0;
      repeat (8) cycle();
      check_eq("stall_done_lat", 32'(done_at - s), 32'd13);
      check_eq("stall_en_cycles", 32'(en_cnt), 32'd9);

      // Abort with stall at cnt=5
      start_pulse();
      repeat (5) cycle();
      stall = 1'b1;
      abort = 1'b1;
      cycle();
      stall = 1'b0;
      abort = 1'b0;
      repeat (12) cycle();
      check_eq("abort5_no_done", 32'(done_at), 32'hffff_ffff);
      start_pulse();
      repeat (12) cycle();
      check_eq("after_abort_done_lat", 32'(done_at - s), 32'd10);
      check_eq("after_abort_en_cycles", 32'(en_cnt), 32'd9);

      // Start held high: back-to-back runs
      clear_stats();
      start = 1'b1;
      cycle();
      s = cyc;
      repeat (20) cycle();
      check_eq("held_ack_count", 32'(ack_cnt), 32'd3);
      check_eq("held_first_done", 32'(done_at - s), 32'd10);
      start = 1'b0;
      repeat (12) cycle();

      // Asynchronous reset while cnt=6
      start_pulse();
      repeat (6) cycle();
      #2 reset_n = 1'b0;
      #1;
      check_eq("async_rst_cnt", 32'(cnt), 32'd0);
      check_eq("async_rst_en", 32'(en), 32'd0);
      check_eq("async_rst_busy", 32'(busy), 32'd0);
      check_eq("async_rst_done", 32'(done), 32'd0);
      m_state = 0;
      m_cnt   = 0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      clear_stats();
      repeat (4) cycle();
      check_eq("post_rst_idle_busy", 32'(busy_cnt), 32'd0);

      // Abort and stall together at cnt=8
      start_pulse();
      repeat (8) cycle();
      stall = 1'b1;
      abort = 1'b1;
      cycle();
      stall = 1'b0;
      abort = 1'b0;
      repeat (4) cycle();
      check_eq("abort8_no_done", 32'(done_at), 32'hffff_ffff);
      check_eq("abort8_en_cycles", 32'(en_cnt), 32'd8);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
